uart_periph: RTL and testbench

Memory-mapped UART responder on the CPU data bus, the slave side of the load/store path that the MEM stage drives. It decodes three word registers at `BASE_ADDR`: transmit data, receive data and control/status. It serialises transmitted bytes onto `tx` and deserialises `rx` into a one-byte receive register. The integrating memory block ORs `ReadData` into its own read mux and gates its store enable on address range.

---
 rtl/uart_periph_pkg.sv | 27 ++
 rtl/uart_rx_core.sv | 91 +++++++++
 rtl/uart_periph.sv | 184 ++++++++++++++++++
 tb/tb_uart_periph.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_periph_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, CON bit
// positions and the 2-bit FSM state encodings used by both serial engines.
package uart_periph_pkg;

  localparam logic [31:0] UART_TXD_OFF = 32'd0;
  localparam logic [31:0] UART_RXD_OFF = 32'd4;
  localparam logic [31:0] UART_CON_OFF = 32'd8;

  localparam int CON_TX_BUSY    = 0;
  localparam int CON_TX_FULL    = 1;
  localparam int CON_RX_VALID   = 2;
  localparam int CON_RX_OVERRUN = 3;
  localparam int CON_FRAME_ERR  = 4;
  localparam int CON_RX_IE      = 5;
  localparam int CON_TX_IE      = 6;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_core.sv
// Receive engine: 2-flop synchroniser, start-bit qualification at mid-bit and
// an 8N1 deserialiser. byteDone/frameErr are single-cycle strobes.
module uart_rx_core
  import uart_periph_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byteDone,
  output logic [7:0] rxByte,
  output logic       frameErr
);

  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DIV - 1);
  localparam logic [CW-1:0]  HALF_CNT = CW'(DIV / 2 - 1);

  logic          rxMeta, rxS, rxPrev;
  logic [1:0]    state;
  logic [CW-1:0] divCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          stopSample;

  // Synchroniser resets to the idle line level so reset release is not seen as a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
      rxPrev <= rxS;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RX_IDLE;
      divCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (rxPrev && !rxS) begin
            state  <= RX_START;
            divCnt <= '0;
          end
        end
        RX_START: begin
          if (divCnt == HALF_CNT) begin
            divCnt <= '0;
            bitCnt <= '0;
            state  <= rxS ? RX_IDLE : RX_DATA;
          end else begin
            divCnt <= divCnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (divCnt == FULL_CNT) begin
            divCnt   <= '0;
            shiftReg <= {rxS, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= RX_STOP;
          end else begin
            divCnt <= divCnt + CW'(1);
          end
        end
        default: begin
          if (divCnt == FULL_CNT) begin
            divCnt <= '0;
            state  <= RX_IDLE;
          end else begin
            divCnt <= divCnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign stopSample = (state == RX_STOP) && (divCnt == FULL_CNT);
  assign byteDone   = stopSample && rxS;
  assign frameErr   = stopSample && !rxS;
  assign rxByte     = shiftReg;

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART slave: TXD/RXD/CON register decode, TX holding register
// and serialiser, receive status bits and a registered level interrupt.
module uart_periph
  import uart_periph_pkg::*;
#(
  parameter int          CLK_FREQ  = 100_000_000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int             DIV      = CLK_FREQ / BAUD;
  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DIV - 1);
  localparam logic [31:0]    TXD_ADDR = BASE_ADDR + UART_TXD_OFF;
  localparam logic [31:0]    RXD_ADDR = BASE_ADDR + UART_RXD_OFF;
  localparam logic [31:0]    CON_ADDR = BASE_ADDR + UART_CON_OFF;

  if (DIV < 4) begin : gBadDiv
    $error("uart_periph: CLK_FREQ/BAUD must be at least 4");
  end

  logic          selTxd, selRxd, selCon;
  logic          txdWrite, conWrite, rxdRead;
  logic [1:0]    txState;
  logic [CW-1:0] txDivCnt;
  logic [2:0]    txBitCnt;
  logic [7:0]    txShift, txHold;
  logic          txLine, txFull, txBusy, txDivEnd, txLoad;
  logic [7:0]    rxData, rxByte;
  logic          rxValid, rxOverrun, frameErr, rxIe, txIe;
  logic          byteDone, rxFrameErr;
  logic [31:0]   conWord;
  logic          unusedBits;

  assign selTxd   = addr[31:2] == TXD_ADDR[31:2];
  assign selRxd   = addr[31:2] == RXD_ADDR[31:2];
  assign selCon   = addr[31:2] == CON_ADDR[31:2];
  assign txdWrite = MemWrite && selTxd;
  assign conWrite = MemWrite && selCon;
  assign rxdRead  = MemRead && selRxd;
  assign unusedBits = ^{addr[1:0], WriteData[31:8]};

  assign txBusy   = txState != TX_IDLE;
  assign txDivEnd = txDivCnt == FULL_CNT;
  // The holding register moves to the shifter from idle or at the end of a stop bit.
  assign txLoad   = txFull && (txState == TX_IDLE || (txState == TX_STOP && txDivEnd));
  assign tx       = txLine;

  uart_rx_core #(.DIV(DIV)) uRxCore (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .byteDone (byteDone),
    .rxByte   (rxByte),
    .frameErr (rxFrameErr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState  <= TX_IDLE;
      txDivCnt <= '0;
      txBitCnt <= '0;
      txShift  <= '0;
      txLine   <= 1'b1;
    end else begin
      case (txState)
        TX_IDLE: begin
          if (txLoad) begin
            txState  <= TX_START;
            txShift  <= txHold;
            txDivCnt <= '0;
            txLine   <= 1'b0;
          end
        end
        TX_START: begin
          if (txDivEnd) begin
            txDivCnt <= '0;
            txBitCnt <= '0;
            txState  <= TX_DATA;
            txLine   <= txShift[0];
          end else begin
            txDivCnt <= txDivCnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (txDivEnd) begin
            txDivCnt <= '0;
            txBitCnt <= txBitCnt + 3'd1;
            txShift  <= {1'b0, txShift[7:1]};
            if (txBitCnt == 3'd7) begin
              txState <= TX_STOP;
              txLine  <= 1'b1;
            end else begin
              txLine <= txShift[1];
            end
          end else begin
            txDivCnt <= txDivCnt + CW'(1);
          end
        end
        default: begin
          if (txDivEnd) begin
            txDivCnt <= '0;
            if (txLoad) begin
              txState <= TX_START;
              txShift <= txHold;
              txLine  <= 1'b0;
            end else begin
              txState <= TX_IDLE;
            end
          end else begin
            txDivCnt <= txDivCnt + CW'(1);
          end
        end
      endcase
    end
  end

  // NOTE: data registers are reset too because their readback value after reset is defined as 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txHold    <= '0;
      txFull    <= 1'b0;
      rxData    <= '0;
      rxValid   <= 1'b0;
      rxOverrun <= 1'b0;
      frameErr  <= 1'b0;
      rxIe      <= 1'b0;
      txIe      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (txdWrite && !txFull) begin
        txHold <= WriteData[7:0];
        txFull <= 1'b1;
      end else if (txLoad) begin
        txFull <= 1'b0;
      end

      if (byteDone) begin
        rxData  <= rxByte;
        rxValid <= 1'b1;
      end else if (rxdRead) begin
        rxValid <= 1'b0;
      end

      // Setting a sticky flag wins over a simultaneous write-1-to-clear.
      if (byteDone && rxValid && !rxdRead) rxOverrun <= 1'b1;
      else if (conWrite && WriteData[CON_RX_OVERRUN]) rxOverrun <= 1'b0;

      if (rxFrameErr) frameErr <= 1'b1;
      else if (conWrite && WriteData[CON_FRAME_ERR]) frameErr <= 1'b0;

      if (conWrite) begin
        rxIe <= WriteData[CON_RX_IE];
        txIe <= WriteData[CON_TX_IE];
      end

      irq <= (rxIe && rxValid) || (txIe && !txFull && !txBusy);
    end
  end

  assign conWord = {25'd0, txIe, rxIe, frameErr, rxOverrun, rxValid, txFull, txBusy};

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      if (selTxd)      ReadData = {24'd0, txHold};
      else if (selRxd) ReadData = {24'd0, rxData};
      else if (selCon) ReadData = conWord;
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph at DIV=16: a register-access vector table plus
// hand-written TX/RX frame sequences covering back-to-back, overrun, framing and reset.
module tb_uart_periph;

  localparam int          DIV  = 16;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] RXD  = BASE + 32'd4;
  localparam logic [31:0] CON  = BASE + 32'd8;

  logic        clk, reset;
  logic [31:0] addr, WriteData, ReadData;
  logic        MemRead, MemWrite;
  logic        rx, tx, irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;  // store data for writes, expected ReadData for reads
  } vec_t;

  vec_t vecs[12];

  uart_periph #(.CLK_FREQ(16), .BAUD(1), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .rx        (rx),
    .tx        (tx),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 32'h%08h, required 32'h%08h", name, act, exp);
    end
  endtask

  // Bus tasks are entered just after a rising edge and return just after the next one.
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    addr = a; WriteData = d; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0; WriteData = '0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    addr = a; MemRead = 1'b1;
    @(negedge clk);
    d = ReadData;
    @(posedge clk); #1;
    MemRead = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    busRead(a, d);
    check(name, d, exp);
  endtask

  task automatic checkFrame(input string name, input logic [7:0] b, input logic leadIdle);
    logic [9:0] bits;
    logic       seen;
    bits = {1'b1, b, 1'b0};
    if (leadIdle) begin
      @(negedge clk);
      check({name, "_lead"}, {31'd0, tx}, 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      seen = bits[i];
      repeat (DIV) begin
        @(negedge clk);
        if (tx !== bits[i]) seen = tx;
      end
      check($sformatf("%s_bit%0d", name, i), {31'd0, seen}, {31'd0, bits[i]});
    end
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"rst_txd",      1'b0, TXD,          32'h0};
    vecs[1]  = '{"rst_rxd",      1'b0, RXD,          32'h0};
    vecs[2]  = '{"rst_con",      1'b0, CON,          32'h0};
    vecs[3]  = '{"unmapped_hi",  1'b0, BASE + 32'd12, 32'h0};
    vecs[4]  = '{"wr_con_7f",    1'b1, CON,          32'h7F};
    vecs[5]  = '{"con_ie_both",  1'b0, CON,          32'h60};
    vecs[6]  = '{"wr_con_20",    1'b1, CON + 32'd2,  32'h20};
    vecs[7]  = '{"con_rx_ie",    1'b0, CON + 32'd1,  32'h20};
    vecs[8]  = '{"wr_rxd",       1'b1, RXD,          32'hFF};
    vecs[9]  = '{"rxd_unchanged",1'b0, RXD,          32'h0};
    vecs[10] = '{"wr_con_0",     1'b1, CON,          32'h0};
    vecs[11] = '{"unmapped_lo",  1'b0, BASE - 32'd4, 32'h0};

    reset = 1'b1; rx = 1'b1; addr = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) busWrite(vecs[i].addr, vecs[i].data);
      else readCheck(vecs[i].name, vecs[i].addr, vecs[i].data);
    end
    readCheck("con_after_table", CON, 32'h0);

    // TX_IE with an idle, empty transmitter raises irq one cycle after the write.
    busWrite(CON, 32'h40);
    check("irq_tx_ie_lag", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_tx_ie", {31'd0, irq}, 32'd1);
    addr = CON; MemRead = 1'b0; #1;
    check("rd_no_strobe", ReadData, 32'h0);
    busWrite(CON, 32'h0);
    @(posedge clk); #1;
    check("irq_tx_ie_off", {31'd0, irq}, 32'd0);

    // Single frame 0xA5 with a CON read in the middle.
    busWrite(TXD, 32'hA5);
    fork
      checkFrame("a5", 8'hA5, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #1;
        readCheck("con_busy", CON, 32'h1);
      end
    join
    @(posedge clk); #1;
    readCheck("con_idle_a5", CON, 32'h0);
    readCheck("txd_readback", TXD, 32'hA5);

    // Back-to-back frames; a store while TX_FULL=1 is dropped.
    busWrite(TXD, 32'h11);
    fork
      begin
        checkFrame("b2b_11", 8'h11, 1'b1);
        checkFrame("b2b_22", 8'h22, 1'b0);
      end
      begin
        @(posedge clk); #1;
        busWrite(TXD, 32'h22);
        readCheck("con_busy_full", CON, 32'h3);
        busWrite(TXD, 32'h99);
        readCheck("txd_drop", TXD, 32'h22);
      end
    join
    @(posedge clk); #1;
    readCheck("con_idle_b2b", CON, 32'h0);

    // Receive 0x3C with RX_IE set.
    busWrite(CON, 32'h20);
    sendRx(8'h3C, 1'b1);
    check("irq_rx", {31'd0, irq}, 32'd1);
    readCheck("rxd_3c", RXD, 32'h3C);
    readCheck("con_rx_cleared", CON, 32'h20);
    check("irq_rx_off", {31'd0, irq}, 32'd0);

    // Two frames without a read give an overrun.
    busWrite(CON, 32'h0);
    sendRx(8'h55, 1'b1);
    sendRx(8'h66, 1'b1);
    readCheck("con_overrun", CON, 32'h0C);
    busWrite(CON, 32'h08);
    readCheck("con_ovr_clr", CON, 32'h04);
    readCheck("rxd_66", RXD, 32'h66);
    readCheck("con_rx_empty", CON, 32'h0);

    // Framing error, then a short glitch that must be rejected.
    sendRx(8'h81, 1'b0);
    readCheck("con_frame_err", CON, 32'h10);
    busWrite(CON, 32'h10);
    readCheck("con_fe_clr", CON, 32'h0);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    readCheck("con_glitch", CON, 32'h0);
    sendRx(8'h5A, 1'b1);
    readCheck("rxd_after_glitch", RXD, 32'h5A);
    readCheck("con_after_5a", CON, 32'h0);

    // Reset 40 cycles into a frame, during data bit 1 (a 0 for 0x44).
    busWrite(TXD, 32'h44);
    repeat (40) @(posedge clk);
    #1;
    check("tx_mid_frame", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    #1;
    check("tx_async_rst", {31'd0, tx}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    readCheck("con_after_rst", CON, 32'h0);
    readCheck("txd_after_rst", TXD, 32'h0);
    busWrite(TXD, 32'hC3);
    checkFrame("c3", 8'hC3, 1'b1);
    @(posedge clk); #1;
    readCheck("con_idle_c3", CON, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
